// File: rtl/code2421_run_ctrl.sv
// code2421_run_ctrl: start/pause/resume/abort sequencing for a one-digit
// 2421 (Aiken) up counter. Stops the counter on a programmed digit after a
// programmed number of 9->0 wraps.
// Optional build macro: CODE2421_CHECK_EN enables illegal-code detection
// (illegal target at start or illegal upcount in RUN both lead to ERR).
module code2421_run_ctrl #(
    parameter int unsigned WRAP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              resume,
    input  logic              abort,
    input  logic [3:0]        target,
    input  logic [WRAP_W-1:0] wraps,
    input  logic [3:0]        upcount,
    output logic              cnt_enable,
    output logic              cnt_clear,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err
);

    localparam int unsigned CODE_W  = 4;
    localparam logic [CODE_W-1:0] CODE_NINE = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CODE_W-1:0]   target_q;
    logic [WRAP_W-1:0]   wraps_q;
    logic [WRAP_W-1:0]   wrap_q;
    logic                cnt_clear_q;
    logic                busy_q;
    logic                done_q;

    logic                up_valid;
    logic                match;
    logic                illegal_up;
    logic                tgt_bad;
    logic                load;
    logic                abort_acc;
    logic                wrap_inc;
    logic                clear_d;

    // Legal 2421 codes for digits 0..9
    function automatic logic code_valid(input logic [CODE_W-1:0] c);
        logic v;
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: v = 1'b1;
            default:                                     v = 1'b0;
        endcase
        return v;
    endfunction

    // Compare and code-check terms shared by next-state and output logic
    always_comb begin
        up_valid = code_valid(upcount);
        match    = (state_q == S_RUN) && up_valid &&
                   (wrap_q == wraps_q) && (upcount == target_q);
`ifdef CODE2421_CHECK_EN
        illegal_up = (state_q == S_RUN) && !up_valid;
        tgt_bad    = !code_valid(target);
`else
        illegal_up = 1'b0;
        tgt_bad    = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; priority abort > match > stop/resume > start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = tgt_bad ? S_ERR : S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (illegal_up) begin
                    state_d = S_ERR;
                end else if (match) begin
                    state_d = S_DONE;
                end else if (stop) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (resume) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = tgt_bad ? S_ERR : S_CLEAR;
                end
            end
            S_ERR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        cnt_enable = (state_q == S_RUN) && !match && !illegal_up;
        load       = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !abort;
        abort_acc  = abort && (state_q != S_IDLE);
        wrap_inc   = cnt_enable && (upcount == CODE_NINE);
        clear_d    = (state_d == S_CLEAR) || abort_acc;
    end

    // Registered status outputs, run parameters and wrap counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            target_q    <= '0;
            wraps_q     <= '0;
            wrap_q      <= '0;
        end else begin
            cnt_clear_q <= clear_d;
            busy_q      <= (state_d == S_CLEAR) || (state_d == S_RUN) ||
                           (state_d == S_PAUSE);
            done_q      <= (state_d == S_DONE);
            if (load) begin
                target_q <= target;
                wraps_q  <= wraps;
                wrap_q   <= '0;
            end else if (abort_acc) begin
                wrap_q   <= '0;
            end else if (wrap_inc && (wrap_q != {WRAP_W{1'b1}})) begin
                wrap_q   <= wrap_q + WRAP_W'(1);
            end
        end
    end

`ifdef CODE2421_CHECK_EN
    logic err_q;

    // Error level mirrors the ERR state
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == S_ERR);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cnt_clear = cnt_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap_cnt  = wrap_q;

endmodule

// File: tb/tb_code2421_run_ctrl.sv
// Directed bench for code2421_run_ctrl with an attached 2421 counter model
// and a queue of expected done-edge cycle numbers.
module tb_code2421_run_ctrl;

    localparam int unsigned WRAP_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              resume;
    logic              abort;
    logic [3:0]        target;
    logic [WRAP_W-1:0] wraps;
    logic [3:0]        upcount;
    logic              cnt_enable;
    logic              cnt_clear;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err;

    code2421_run_ctrl #(.WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .resume     (resume),
        .abort      (abort),
        .target     (target),
        .wraps      (wraps),
        .upcount    (upcount),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .busy       (busy),
        .done       (done),
        .wrap_cnt   (wrap_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 2421 counter model driven by the controller
    int         idx = 0;
    logic       frc = 1'b0;
    logic [3:0] frc_val = 4'b0000;

    function automatic logic [3:0] d2c(input int d);
        logic [3:0] c;
        case (d)
            0: c = 4'b0000;
            1: c = 4'b0001;
            2: c = 4'b0010;
            3: c = 4'b0011;
            4: c = 4'b0100;
            5: c = 4'b1011;
            6: c = 4'b1100;
            7: c = 4'b1101;
            8: c = 4'b1110;
            9: c = 4'b1111;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    always @(posedge clk) begin
        if (cnt_clear === 1'b1) idx <= 0;
        else if (cnt_enable === 1'b1) idx <= (idx == 9) ? 0 : idx + 1;
    end

    assign upcount = frc ? frc_val : d2c(idx);

    int checks = 0;
    int fails  = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int exp_q[$];
    int e0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        en_cnt  += (cnt_enable === 1'b1) ? 1 : 0;
        clr_cnt += (cnt_clear === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] t, input int w, output int edge0);
        target  = t;
        wraps   = WRAP_W'(w);
        start   = 1'b1;
        en_cnt  = 0;
        clr_cnt = 0;
        tick();
        start   = 1'b0;
        edge0   = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (exp_q.size() > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_up(input string tag, input logic [3:0] code);
        int n = 0;
        while (upcount !== code && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_reach"}, 32'(upcount), 32'(code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        resume = 1'b0;
        abort  = 1'b0;
        target = 4'b0000;
        wraps  = '0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_en",    32'(cnt_enable), 32'd0);
        check("rst_clr",   32'(cnt_clear),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_wrap",  32'(wrap_cnt),   32'd0);
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Run A: digit 7 after one wrap
        start_run(4'b1101, 1, e0);
        exp_q.push_back(e0 + 19);
        check("a_clear", 32'(cnt_clear), 32'd1);
        check("a_busy",  32'(busy),      32'd1);
        wait_done("a");
        check("a_en_cycles",  32'(en_cnt),   32'd17);
        check("a_clr_cycles", 32'(clr_cnt),  32'd1);
        check("a_wrap",       32'(wrap_cnt), 32'd1);
        check("a_up",         32'(upcount),  32'hD);
        check("a_busy_off",   32'(busy),     32'd0);
        tick();
        tick();
        check("a_hold_up",   32'(upcount), 32'hD);
        check("a_hold_done", 32'(done),    32'd1);

        // Run B: digit 0, no wraps, from DONE
        start_run(4'b0000, 0, e0);
        exp_q.push_back(e0 + 2);
        wait_done("b");
        check("b_en_cycles", 32'(en_cnt),   32'd0);
        check("b_wrap",      32'(wrap_cnt), 32'd0);
        check("b_up",        32'(upcount),  32'h0);

        // Run C: digit 9 with a three-cycle pause at digit 4
        start_run(4'b1111, 0, e0);
        exp_q.push_back(e0 + 14);
        wait_up("c", 4'b0011);
        stop = 1'b1;
        tick();
        check("c_pause_en", 32'(cnt_enable), 32'd0);
        check("c_pause_up", 32'(upcount),    32'h4);
        tick();
        tick();
        stop = 1'b0;
        check("c_pause_up2",  32'(upcount), 32'h4);
        check("c_pause_busy", 32'(busy),    32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        wait_done("c");
        check("c_en_cycles", 32'(en_cnt),  32'd9);
        check("c_up",        32'(upcount), 32'hF);

        // Run D: abort during RUN at digit 3
        start_run(4'b1111, 1, e0);
        wait_up("d", 4'b0011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("d_busy", 32'(busy),       32'd0);
        check("d_clr",  32'(cnt_clear),  32'd1);
        check("d_wrap", 32'(wrap_cnt),   32'd0);
        check("d_done", 32'(done),       32'd0);
        check("d_en",   32'(cnt_enable), 32'd0);
        tick();
        check("d_clr_end", 32'(cnt_clear), 32'd0);
        check("d_up_zero", 32'(upcount),   32'h0);

        // Run E: start and abort together while DONE
        start_run(4'b0000, 0, e0);
        exp_q.push_back(e0 + 2);
        wait_done("e");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("e_busy", 32'(busy),      32'd0);
        check("e_done", 32'(done),      32'd0);
        check("e_clr",  32'(cnt_clear), 32'd1);
        tick();

        // Run F: illegal upcount forced during RUN
        start_run(4'b1111, 1, e0);
        tick();
        tick();
        frc     = 1'b1;
        frc_val = 4'b0110;
        #1;
`ifdef CODE2421_CHECK_EN
        check("f_en_forced", 32'(cnt_enable), 32'd0);
        tick();
        check("f_err",  32'(err),  32'd1);
        check("f_busy", 32'(busy), 32'd0);
        frc   = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("f_err_clr", 32'(err),       32'd0);
        check("f_abort",   32'(cnt_clear), 32'd1);
        tick();
        // Illegal target code at start
        start_run(4'b0111, 0, e0);
        check("g_err",  32'(err),  32'd1);
        check("g_busy", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("g_err_clr", 32'(err), 32'd0);
`else
        check("f_en_forced", 32'(cnt_enable), 32'd1);
        tick();
        check("f_err",  32'(err),  32'd0);
        check("f_busy", 32'(busy), 32'd1);
        frc   = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("f_abort", 32'(busy), 32'd0);
        tick();
        // Illegal target latched as-is: run never completes
        start_run(4'b0111, 0, e0);
        for (int i = 0; i < 25; i++) tick();
        check("g_busy", 32'(busy), 32'd1);
        check("g_done", 32'(done), 32'd0);
        check("g_err",  32'(err),  32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        tick();

        // Run H: reset dropped while paused, then a normal run
        start_run(4'b1111, 0, e0);
        wait_up("h", 4'b0011);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("h_paused", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check("h_rst_busy", 32'(busy),       32'd0);
        check("h_rst_clr",  32'(cnt_clear),  32'd0);
        check("h_rst_en",   32'(cnt_enable), 32'd0);
        check("h_rst_wrap", 32'(wrap_cnt),   32'd0);
        check("h_rst_done", 32'(done),       32'd0);
        reset = 1'b1;
        tick();
        check("h_no_clr", 32'(cnt_clear), 32'd0);
        start_run(4'b0011, 0, e0);
        exp_q.push_back(e0 + 5);
        wait_done("h");
        check("h_en_cycles", 32'(en_cnt),  32'd3);
        check("h_up",        32'(upcount), 32'h3);
        check("h_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
